// File: rtl/boundary_scan_register_if.sv
// rtl/boundary_scan_register_if.sv - TAP-side control and scan signals of the boundary-scan register
interface boundary_scan_register_if;
  logic TDI;
  logic CaptureDR;
  logic ShiftDR;
  logic UpdateDR;
  logic Mode;
  logic TDO;
  logic length_err;

  modport master (
    output TDI, CaptureDR, ShiftDR, UpdateDR, Mode,
    input  TDO, length_err
  );

  modport slave (
    input  TDI, CaptureDR, ShiftDR, UpdateDR, Mode,
    output TDO, length_err
  );
endinterface

// File: rtl/boundary_scan_register.sv
// rtl/boundary_scan_register.sv - N data cells plus one OE control cell with shift and update stages
// Optional shift-length checking on update is enabled by defining BSR_LENGTH_CHECK_EN.
module boundary_scan_register #(
  parameter int   N        = 16,
  parameter logic RESET_OE = 1'b0
) (
  input  logic                          TCK,
  input  logic                          TRST,
  boundary_scan_register_if.slave       tap,
  input  logic [N-1:0]                  module_pin_data,
  input  logic                          module_pin_oe,
  output logic [N-1:0]                  sys_pin_data,
  output logic                          sys_pin_oe
);

  logic [N:0] sh;
  logic [N:0] upd;
  logic       update_ok;

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      sh  <= '0;
      upd <= {RESET_OE, {N{1'b0}}};
    end else begin
      if (tap.CaptureDR)
        sh <= {module_pin_oe, module_pin_data};
      else if (tap.ShiftDR)
        sh <= {sh[N-1:0], tap.TDI};
      // upd takes the pre-edge sh, so a same-cycle capture or shift does not leak in
      if (tap.UpdateDR && update_ok)
        upd <= sh;
    end
  end

`ifdef BSR_LENGTH_CHECK_EN
  localparam int CW = $clog2(N + 3);

  logic [CW-1:0] shift_cnt;
  logic          err;

  // only an exact N+1-bit scan is a well-formed load; the count saturates so long scans stay wrong
  assign update_ok = (shift_cnt == CW'(N + 1));

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      shift_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (tap.CaptureDR)
        shift_cnt <= '0;
      else if (tap.ShiftDR && (shift_cnt != CW'(N + 2)))
        shift_cnt <= shift_cnt + CW'(1);
      if (tap.UpdateDR)
        err <= !update_ok;
    end
  end

  assign tap.length_err = err;
`else
  assign update_ok      = 1'b1;
  assign tap.length_err = 1'b0;
`endif

  assign tap.TDO      = sh[N];
  assign sys_pin_data = tap.Mode ? upd[N-1:0] : module_pin_data;
  assign sys_pin_oe   = tap.Mode ? upd[N]     : module_pin_oe;

endmodule

// File: tb/tb_boundary_scan_register.sv
// tb/tb_boundary_scan_register.sv - directed checks of the boundary-scan register with N=4
module tb_boundary_scan_register;
  localparam int N = 4;

  logic         TCK = 1'b0;
  logic         TRST;
  logic [N-1:0] module_pin_data;
  logic         module_pin_oe;
  logic [N-1:0] sys_pin_data;
  logic         sys_pin_oe;

  int n_checks = 0;
  int n_fail   = 0;

  boundary_scan_register_if tap ();

  boundary_scan_register #(.N(N), .RESET_OE(1'b0)) dut (
    .TCK             (TCK),
    .TRST            (TRST),
    .tap             (tap.slave),
    .module_pin_data (module_pin_data),
    .module_pin_oe   (module_pin_oe),
    .sys_pin_data    (sys_pin_data),
    .sys_pin_oe      (sys_pin_oe)
  );

  always #5 TCK = ~TCK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge TCK);
    #1;
  endtask

  task automatic idle();
    tap.CaptureDR = 1'b0;
    tap.ShiftDR   = 1'b0;
    tap.UpdateDR  = 1'b0;
  endtask

  task automatic capture(input logic [N-1:0] d, input logic oe);
    module_pin_data = d;
    module_pin_oe   = oe;
    tap.CaptureDR   = 1'b1;
    cycle();
    idle();
  endtask

  // shift cnt bits, first bit taken from bits[0]
  task automatic shift_in(input int cnt, input logic [7:0] bits);
    for (int i = 0; i < cnt; i++) begin
      tap.TDI     = bits[i];
      tap.ShiftDR = 1'b1;
      cycle();
    end
    idle();
  endtask

  task automatic update();
    tap.UpdateDR = 1'b1;
    cycle();
    idle();
  endtask

  task automatic check_pins(input string tag, input logic [N-1:0] d, input logic oe, input logic err);
    check_eq({tag, "_data"}, 32'(sys_pin_data), 32'(d));
    check_eq({tag, "_oe"},   32'(sys_pin_oe),   32'(oe));
    check_eq({tag, "_err"},  32'(tap.length_err), 32'(err));
  endtask

  logic [4:0] tdo_exp;
  logic [4:0] tdi_seq;
  bit         len_chk;

  initial begin
`ifdef BSR_LENGTH_CHECK_EN
    len_chk = 1'b1;
`else
    len_chk = 1'b0;
`endif
    TRST            = 1'b0;
    tap.Mode        = 1'b1;
    tap.TDI         = 1'b0;
    module_pin_data = 4'hF;
    module_pin_oe   = 1'b1;
    idle();
    cycle();
    check_pins("reset", 4'h0, 1'b0, 1'b0);
    check_eq("reset_tdo", 32'(tap.TDO), 32'd0);
    TRST = 1'b1;

    // capture A/oe=1 -> sh=1_1010; shift in 1,0,1,1,0 while watching TDO
    capture(4'hA, 1'b1);
    tdo_exp = 5'b01011;
    tdi_seq = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      tap.TDI     = tdi_seq[i];
      tap.ShiftDR = 1'b1;
      check_eq($sformatf("tdo_bit%0d", i), 32'(tap.TDO), 32'(tdo_exp[i]));
      cycle();
    end
    idle();
    check_pins("pre_update", 4'h0, 1'b0, 1'b0);
    update();
    check_pins("update", 4'b0110, 1'b1, 1'b0);

    // functional pass-through and zero-latency Mode switch
    tap.Mode        = 1'b0;
    module_pin_data = 4'h5;
    module_pin_oe   = 1'b0;
    #1;
    check_eq("pass_data", 32'(sys_pin_data), 32'h5);
    check_eq("pass_oe",   32'(sys_pin_oe),   32'h0);
    tap.Mode = 1'b1;
    #1;
    check_eq("mode_back_data", 32'(sys_pin_data), 32'h6);
    check_eq("mode_back_oe",   32'(sys_pin_oe),   32'h1);

    // short scan: sh 0_0011 -> 1_1111 after three 1s
    capture(4'h3, 1'b0);
    shift_in(3, 8'b111);
    update();
    if (len_chk) check_pins("short", 4'h6, 1'b1, 1'b1);
    else         check_pins("short", 4'hF, 1'b1, 1'b0);

    // correct scan: TDI 0,0,1,0,1 -> sh 0_0101
    capture(4'h3, 1'b0);
    shift_in(5, 8'b10100);
    update();
    check_pins("full", 4'h5, 1'b0, 1'b0);

    // overlong scan: six 1s -> sh 1_1111
    capture(4'h0, 1'b0);
    shift_in(6, 8'b111111);
    update();
    if (len_chk) check_pins("long", 4'h5, 1'b0, 1'b1);
    else         check_pins("long", 4'hF, 1'b1, 1'b0);

    // capture 9/oe=1, shift 0,1,1,0,0 -> sh 0_1100, then shift and update together
    capture(4'h9, 1'b1);
    shift_in(5, 8'b00110);
    check_eq("pre_simul_tdo", 32'(tap.TDO), 32'd0);
    tap.TDI      = 1'b1;
    tap.ShiftDR  = 1'b1;
    tap.UpdateDR = 1'b1;
    cycle();
    idle();
    check_pins("simul", 4'hC, 1'b0, 1'b0);
    check_eq("simul_tdo", 32'(tap.TDO), 32'd1);

    // sh is now 1_1001 with six shifts counted
    update();
    if (len_chk) check_pins("after_simul", 4'hC, 1'b0, 1'b1);
    else         check_pins("after_simul", 4'h9, 1'b1, 1'b0);

    // reset in the middle of a shift overrides it
    tap.TDI     = 1'b1;
    tap.ShiftDR = 1'b1;
    TRST        = 1'b0;
    cycle();
    idle();
    TRST = 1'b1;
    check_pins("mid_reset", 4'h0, 1'b0, 1'b0);
    check_eq("mid_reset_tdo", 32'(tap.TDO), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boundary_scan_register.md
BOUNDARY_SCAN_REGISTER -- requirements
Module: boundary_scan_register

Interface
REQ-001 SHALL have parameter N, default 16, number of data output cells (N >= 1).
REQ-002 SHALL have parameter RESET_OE, default 1'b0, reset value of the output-enable cell's update stage.
REQ-003 SHALL have port TCK, input, 1, the only clock; all state updates on the rising edge.
REQ-004 SHALL have port TRST, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port TDI, input, 1, serial scan in.
REQ-006 SHALL have port CaptureDR, input, 1, parallel-capture enable.
REQ-007 SHALL have port ShiftDR, input, 1, shift enable.
REQ-008 SHALL have port UpdateDR, input, 1, update enable.
REQ-009 SHALL have port Mode, input, 1, where 1 selects test drive and 0 selects functional pass-through.
REQ-010 SHALL have port module_pin_data, input, N, core-side data.
REQ-011 SHALL have port module_pin_oe, input, 1, core-side output enable.
REQ-012 SHALL have port sys_pin_data, output, N, pad-side data.
REQ-013 SHALL have port sys_pin_oe, output, 1, pad-side output enable.
REQ-014 SHALL have port TDO, output, 1, serial scan out.
REQ-015 SHALL have port length_err, output, 1, sticky shift-length error flag.

Function
REQ-016 SHALL hold an (N+1)-bit shift stage sh: bits [N-1:0] are the data cells and bit N is the OE control cell; bit 0 is nearest TDI.
REQ-017 SHALL, on CaptureDR=1, load sh <= {module_pin_oe, module_pin_data}; CaptureDR SHALL take priority over ShiftDR when both are high.
REQ-018 SHALL, on ShiftDR=1 with CaptureDR=0, load sh <= {sh[N-1:0], TDI}; sh SHALL hold otherwise.
REQ-019 SHALL drive TDO = sh[N] directly from the flop, so the first shifted-out bit is the captured OE and a full scan is N+1 ShiftDR cycles.
REQ-020 SHALL hold an (N+1)-bit update stage upd, loaded from the pre-edge value of sh on an UpdateDR cycle, subject to REQ-024; upd SHALL be unaffected by concurrent Capture or Shift in the same cycle.
REQ-021 SHALL drive sys_pin_data = Mode ? upd[N-1:0] : module_pin_data and sys_pin_oe = Mode ? upd[N] : module_pin_oe combinationally; a Mode change SHALL take effect with zero latency.
REQ-022 SHALL deliver an updated value to the pads in the cycle after the UpdateDR edge when Mode=1.

Reset
REQ-023 SHALL, when TRST=0 at a TCK edge, set sh <= 0, upd[N-1:0] <= 0, upd[N] <= RESET_OE, length_err <= 0, and the shift counter <= 0; reset SHALL override Capture, Shift and Update, and a reset asserted mid-scan SHALL discard the partial scan.

Configuration
REQ-024 SHALL, with macro BSR_LENGTH_CHECK_EN defined, keep a shift counter that is cleared on CaptureDR, incremented on each ShiftDR cycle without CaptureDR, and saturates at N+2. On UpdateDR, if the pre-edge count == N+1, upd SHALL load and length_err SHALL clear; otherwise upd SHALL hold and length_err SHALL set and stay set until the next accepted update or reset. When CaptureDR and UpdateDR are high together, the check SHALL use the pre-edge count.
REQ-025 SHALL, without BSR_LENGTH_CHECK_EN, omit the counter, make every UpdateDR load upd unconditionally, and tie length_err to 0.

Verification (N=4, RESET_OE=0)
REQ-026 SHALL cover reset: TRST=0 for 1 cycle with Mode=1 -> sys_pin_data=4'h0, sys_pin_oe=0, TDO=0, length_err=0.
REQ-027 SHALL cover capture and shift-out: module_pin_data=4'hA, module_pin_oe=1, 1 CaptureDR cycle, then 5 ShiftDR cycles -> TDO sequence before each shift edge = 1,1,0,1,0.
REQ-028 SHALL cover shift-in and update: 5 ShiftDR cycles with TDI = 1,0,1,1,0 (first to last), then UpdateDR with Mode=1 -> next cycle sys_pin_oe=1, sys_pin_data=4'b0110.
REQ-029 SHALL cover pass-through: Mode=0, module_pin_data=4'h5, module_pin_oe=0 -> sys_pin_data=4'h5 and sys_pin_oe=0 in the same cycle, regardless of upd.
REQ-030 SHALL cover a short scan with BSR_LENGTH_CHECK_EN: CaptureDR, 3 ShiftDR cycles, UpdateDR -> upd unchanged and length_err=1; then CaptureDR, 5 ShiftDR cycles, UpdateDR -> upd loaded and length_err=0.
REQ-031 SHALL cover simultaneous events: ShiftDR=1 and UpdateDR=1 in the same cycle -> upd takes the pre-shift sh and sh shifts by one; TRST=0 during a shift -> the REQ-023 values appear on the next cycle.
